toggle_energy_monitor: RTL and testbench



---
 rtl/toggle_energy_monitor.sv | 140 ++++++++++++++
 tb/tb_toggle_energy_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/toggle_energy_monitor.sv
// Counts synchronised transitions of an async gate output per window and reports count, energy (pJ), alarm and sat.
// Latency: sig edge counted two clocks after capture; report registered at window end; no backpressure, one done pulse per window.
module toggle_energy_monitor #(
  parameter int CNT_W        = 16,
  parameter int ACC_W        = 32,
  parameter int WIN_W        = 16,
  parameter int E_PER_TOGGLE = 545
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             sig,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] toggle_count,
  output logic [ACC_W-1:0] energy,
  output logic             done,
  output logic             alarm,
  output logic             sat
);

  localparam logic [ACC_W-1:0] LP_E = ACC_W'(E_PER_TOGGLE);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic [WIN_W-1:0] r_win_q;
  logic [WIN_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat_int;
  logic [CNT_W-1:0] r_toggle_count;
  logic [ACC_W-1:0] r_energy;
  logic             r_done, r_alarm, r_sat;

  logic             w_go, w_last, w_start, w_win_end;
  logic             w_tog, w_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_sat_nxt;

  assign w_go      = enable && (window_len != '0);
  assign w_last    = (r_cyc == (r_win_q - WIN_W'(1)));
  assign w_tog     = r_s2 ^ r_s3;
  assign w_inc     = w_tog && !(&r_cnt);
  assign w_cnt_nxt = r_cnt + CNT_W'(w_inc);
  assign w_acc_nxt = w_inc ? (r_acc + LP_E) : r_acc;
  // Flag is sticky once the counter has reached all ones within the window.
  assign w_sat_nxt = r_sat_int | (&w_cnt_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_win_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_RUN;
          w_start     = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_win_end = 1'b1;
          if (w_go) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s1    <= sig;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_win_q   <= '0;
      r_cyc     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sat_int <= 1'b0;
    end else if (w_start) begin
      r_win_q   <= window_len;
      r_cyc     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sat_int <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_cyc     <= r_cyc + WIN_W'(1);
      r_cnt     <= w_cnt_nxt;
      r_acc     <= w_acc_nxt;
      r_sat_int <= w_sat_nxt;
    end
  end

  // Report uses the next-state counters so a toggle in the final cycle is included.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_toggle_count <= '0;
      r_energy       <= '0;
      r_done         <= 1'b0;
      r_alarm        <= 1'b0;
      r_sat          <= 1'b0;
    end else begin
      r_done <= w_win_end;
      if (w_win_end) begin
        r_toggle_count <= w_cnt_nxt;
        r_energy       <= w_acc_nxt;
        r_alarm        <= (w_cnt_nxt > threshold);
        r_sat          <= w_sat_nxt;
      end
    end
  end

  assign toggle_count = r_toggle_count;
  assign energy       = r_energy;
  assign done         = r_done;
  assign alarm        = r_alarm;
  assign sat          = r_sat;

endmodule

// File: tb/tb_toggle_energy_monitor.sv
// Directed bench: default-width and 4-bit-counter instances share stimulus; expected reports are queued per window.
module tb_toggle_energy_monitor;

  localparam int E = 545;

  logic        clk = 1'b0;
  logic        reset_L, sig, enable;
  logic [15:0] window_len, threshold;

  logic [15:0] c0;
  logic [31:0] e0;
  logic        d0, a0, s0;
  logic [3:0]  c4;
  logic [31:0] e4;
  logic        d4, a4, s4;

  toggle_energy_monitor u_dut (
    .clk(clk), .reset_L(reset_L), .sig(sig), .enable(enable),
    .window_len(window_len), .threshold(threshold),
    .toggle_count(c0), .energy(e0), .done(d0), .alarm(a0), .sat(s0)
  );

  toggle_energy_monitor #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset_L(reset_L), .sig(sig), .enable(enable),
    .window_len(window_len), .threshold(threshold[3:0]),
    .toggle_count(c4), .energy(e4), .done(d4), .alarm(a4), .sat(s4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cnt;
    int   eng;
    logic alarm;
    logic sat;
    int   due;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];
  exp_t m0, m4;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   k, m, p, r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n toggles seen in the window, thr = threshold at window end, due = cycle the done pulse is visible
  task automatic expect_win(input int n, input int thr, input int due);
    exp_t e;
    e.cnt   = n;
    e.eng   = n * E;
    e.alarm = (n > thr);
    e.sat   = 1'b0;
    e.due   = due;
    q0.push_back(e);
    e.cnt   = (n > 15) ? 15 : n;
    e.eng   = e.cnt * E;
    e.alarm = (e.cnt > (thr % 16));
    e.sat   = (n >= 15);
    q4.push_back(e);
  endtask

  task automatic check_zero();
    check("rst_count", c0, 0);
    check("rst_energy", e0, 0);
    check("rst_done", d0, 0);
    check("rst_alarm", a0, 0);
    check("rst_sat", s0, 0);
    check("rst4_count", c4, 0);
    check("rst4_energy", e4, 0);
    check("rst4_done", d4, 0);
    check("rst4_alarm", a4, 0);
    check("rst4_sat", s4, 0);
  endtask

  always @(negedge clk) begin
    check("done", d0, (q0.size() > 0 && q0[0].due == cyc));
    if (q0.size() > 0 && q0[0].due == cyc) begin
      m0 = q0.pop_front();
      if (d0) begin
        check("count", c0, m0.cnt);
        check("energy", e0, m0.eng);
        check("alarm", a0, m0.alarm);
        check("sat", s0, m0.sat);
      end
    end
    check("done4", d4, (q4.size() > 0 && q4[0].due == cyc));
    if (q4.size() > 0 && q4[0].due == cyc) begin
      m4 = q4.pop_front();
      if (d4) begin
        check("count4", c4, m4.cnt);
        check("energy4", e4, m4.eng);
        check("alarm4", a4, m4.alarm);
        check("sat4", s4, m4.sat);
      end
    end
  end

  initial begin
    reset_L    = 1'b0;
    sig        = 1'b1;
    enable     = 1'b0;
    window_len = 16'd0;
    threshold  = 16'd0;
    #2;
    check_zero();

    @(negedge clk);
    reset_L = 1'b1;
    repeat (3) @(negedge clk);

    // Three back-to-back 10-cycle windows: static, five toggles, static.
    enable     = 1'b1;
    window_len = 16'd10;
    k = cyc + 1;
    expect_win(0, 0, k + 10);
    expect_win(5, 3, k + 20);
    expect_win(0, 3, k + 30);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i >= 9 && i <= 17 && (i % 2) == 1) sig = ~sig;
      if (i == 10) threshold = 16'd3;
      if (i == 29) enable = 1'b0;
    end
    repeat (5) @(negedge clk);

    // 20 toggles in a 40-cycle window: 4-bit instance saturates at 15.
    window_len = 16'd40;
    threshold  = 16'd20;
    enable     = 1'b1;
    sig        = ~sig;
    m = cyc + 1;
    expect_win(20, 20, m + 40);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((i % 2) == 1 && i <= 37) sig = ~sig;
      if (i == 39) enable = 1'b0;
    end
    repeat (5) @(negedge clk);

    // Window abandoned at cycle 5: no report, previous report held.
    window_len = 16'd10;
    enable     = 1'b1;
    sig        = ~sig;
    p = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) sig = ~sig;
      if (i == 4) enable = 1'b0;
    end
    check("hold_count", c0, 20);
    check("hold_energy", e0, 20 * E);
    check("hold_alarm", a0, 0);
    check("hold_sat", s0, 0);
    check("hold4_count", c4, 15);
    check("hold4_energy", e4, 15 * E);
    check("hold4_alarm", a4, 1);
    check("hold4_sat", s4, 1);
    repeat (2) @(negedge clk);

    // Re-enable; a mid-window window_len change must not shorten this window.
    enable = 1'b1;
    p = cyc + 1;
    expect_win(2, 20, p + 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1 || i == 3) sig = ~sig;
      if (i == 2) window_len = 16'd3;
      if (i == 9) enable = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges in the middle of a window.
    window_len = 16'd10;
    enable     = 1'b1;
    r = cyc + 1;
    repeat (4) @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    check_zero();
    @(negedge clk);
    window_len = 16'd0;
    @(negedge clk);
    reset_L = 1'b1;
    repeat (30) @(negedge clk);
    check_zero();

    check("q0_drained", q0.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
